// File: rtl/regfile_wb_pkg.sv
// Shared types and sizing for the register file with write-back queue.
package regfile_wb_pkg;

  localparam int XLEN   = 32;
  localparam int NREG   = 32;
  localparam int REG_AW = 5;
  localparam int QDEPTH = 2;

  typedef logic [XLEN-1:0]   word_t;
  typedef logic [REG_AW-1:0] regAddr_t;

  // One pending write-back: destination register and its value.
  typedef struct packed {
    regAddr_t rd;
    word_t    data;
  } wbEntry_t;

  // Resolves a read port: x0 is hard zero; otherwise the youngest pending
  // write to the same register wins over the older one, which wins over
  // the committed array contents.
  function automatic word_t bypassRead(
    input regAddr_t   addr,
    input word_t      arrayVal,
    input logic [1:0] count,
    input wbEntry_t   head,
    input wbEntry_t   young
  );
    word_t result;
    result = arrayVal;
    if ((count != 2'd0) && (head.rd == addr)) begin
      result = head.data;
    end
    if ((count == 2'd2) && (young.rd == addr)) begin
      result = young.data;
    end
    if (addr == '0) begin
      result = '0;
    end
    return result;
  endfunction

endpackage

// File: rtl/regfile_wb_if.sv
// Bus between execute/write-back, decode/issue and the register file.
interface regfile_wb_if;
  import regfile_wb_pkg::*;

  logic     wb_valid;
  logic     wb_ready;
  regAddr_t wb_rd;
  word_t    wb_data;
  logic     wr_hold;
  logic     iss_valid;
  regAddr_t iss_rd;
  regAddr_t rs1_addr;
  word_t    rs1_data;
  logic     rs1_busy;
  regAddr_t rs2_addr;
  word_t    rs2_data;
  logic     rs2_busy;

  // Producer/consumer side that drives requests and read addresses.
  modport master (
    output wb_valid, wb_rd, wb_data, wr_hold, iss_valid, iss_rd, rs1_addr, rs2_addr,
    input  wb_ready, rs1_data, rs1_busy, rs2_data, rs2_busy
  );

  // Register file side.
  modport slave (
    input  wb_valid, wb_rd, wb_data, wr_hold, iss_valid, iss_rd, rs1_addr, rs2_addr,
    output wb_ready, rs1_data, rs1_busy, rs2_data, rs2_busy
  );

endinterface

// File: rtl/regfile_wb_dec32.sv
// 5-to-32 one-hot decoder used to build the register write-enable vector.
module regfile_wb_dec32 (
  input  logic [4:0]  i_sel,
  output logic [31:0] o_onehot
);

  assign o_onehot = 32'd1 << i_sel;

endmodule

// File: rtl/regfile_wb.sv
// 32-entry register file fed through a 2-deep write-back queue, with a busy
// scoreboard for issued destinations. Pending queue entries are bypassed to
// the read ports so a value is visible the cycle after it is accepted.
module regfile_wb
  import regfile_wb_pkg::*;
(
  input logic         clk,
  input logic         rst,
  regfile_wb_if.slave bus
);

  wbEntry_t        r_queue [QDEPTH];
  logic            r_head;
  logic            r_tail;
  logic [1:0]      r_count;
  word_t           r_regs [NREG];
  logic [NREG-1:0] r_busy;

  logic            w_push;
  logic            w_commit;
  wbEntry_t        w_headEntry;
  wbEntry_t        w_youngEntry;
  logic [NREG-1:0] w_dec;
  logic [NREG-1:0] w_we;
  logic [NREG-1:0] w_busyNext;

  assign bus.wb_ready = !rst && (r_count < 2'(QDEPTH));
  assign w_push       = bus.wb_valid && bus.wb_ready;
  assign w_commit     = (r_count != 2'd0) && !bus.wr_hold;
  assign w_headEntry  = r_queue[r_head];
  assign w_youngEntry = r_queue[~r_head];

  regfile_wb_dec32 u_dec32 (
    .i_sel    (w_headEntry.rd),
    .o_onehot (w_dec)
  );

  // Write enables follow the queue head only when it actually commits; x0 is never written.
  always_comb begin
    w_we    = w_dec & {NREG{w_commit}};
    w_we[0] = 1'b0;
  end

  // Queue pointers and occupancy; push and pop may both happen on one edge.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
      r_count <= 2'd0;
    end else begin
      if (w_push) begin
        r_tail <= ~r_tail;
      end
      if (w_commit) begin
        r_head <= ~r_head;
      end
      r_count <= r_count + 2'(w_push) - 2'(w_commit);
    end
  end

  // Queue payload storage; contents are only meaningful below the count.
  always_ff @(posedge clk) begin
    if (!rst && w_push) begin
      r_queue[r_tail] <= '{rd: bus.wb_rd, data: bus.wb_data};
    end
  end

  // Architectural registers, written from the queue head on commit.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NREG; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      for (int i = 1; i < NREG; i++) begin
        if (w_we[i]) begin
          r_regs[i] <= w_headEntry.data;
        end
      end
    end
  end

  // Scoreboard update: commit clears, a same-edge issue re-sets and wins.
  always_comb begin
    w_busyNext = r_busy & ~w_we;
    if (bus.iss_valid && (bus.iss_rd != '0)) begin
      w_busyNext[bus.iss_rd] = 1'b1;
    end
    w_busyNext[0] = 1'b0;
  end

  // Scoreboard register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_busy <= '0;
    end else begin
      r_busy <= w_busyNext;
    end
  end

  assign bus.rs1_data = bypassRead(bus.rs1_addr, r_regs[bus.rs1_addr], r_count,
                                   w_headEntry, w_youngEntry);
  assign bus.rs2_data = bypassRead(bus.rs2_addr, r_regs[bus.rs2_addr], r_count,
                                   w_headEntry, w_youngEntry);
  assign bus.rs1_busy = r_busy[bus.rs1_addr];
  assign bus.rs2_busy = r_busy[bus.rs2_addr];

endmodule

// File: tb/tb_regfile_wb.sv
// Directed bench for regfile_wb: reset, write-back with bypass, queue
// fill/hold, scoreboard, push+pop ordering and reset with pending entries.
module tb_regfile_wb;

  logic clk;
  logic rst;
  int   assertCount;
  int   failCount;

  regfile_wb_if bus ();

  regfile_wb dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Compares one observed value against its hand-computed expectation.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drives the write-back and issue inputs for the coming edge.
  task automatic applyStimulus(input logic wbValid, input logic [4:0] wbRd,
                               input logic [31:0] wbData, input logic hold,
                               input logic issValid, input logic [4:0] issRd);
    bus.wb_valid  = wbValid;
    bus.wb_rd     = wbRd;
    bus.wb_data   = wbData;
    bus.wr_hold   = hold;
    bus.iss_valid = issValid;
    bus.iss_rd    = issRd;
  endtask

  // Advances past one rising edge; inputs change 1 ns after the edge.
  task automatic stepClock();
    @(posedge clk);
    #1;
  endtask

  // Sets read addresses and lets the combinational read paths settle.
  task automatic readPorts(input logic [4:0] a1, input logic [4:0] a2);
    bus.rs1_addr = a1;
    bus.rs2_addr = a2;
    #1;
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    rst = 1'b1;
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd5, 5'd0);

    // Reset: two edges with rst high, then release.
    stepClock();
    stepClock();
    readPorts(5'd5, 5'd0);
    checkOutput("ready_in_reset", 32'(bus.wb_ready), 32'd0);
    rst = 1'b0;
    readPorts(5'd5, 5'd0);
    checkOutput("ready_after_reset", 32'(bus.wb_ready), 32'd1);
    checkOutput("rs1_x5_reset", bus.rs1_data, 32'h0);
    checkOutput("rs1_busy_reset", 32'(bus.rs1_busy), 32'd0);

    // Basic write: no same-cycle bypass, then bypass, then commit.
    applyStimulus(1'b1, 5'd5, 32'hDEADBEEF, 1'b0, 1'b0, 5'd0);
    readPorts(5'd5, 5'd0);
    checkOutput("no_same_cycle_bypass", bus.rs1_data, 32'h0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd5, 5'd0);
    checkOutput("bypass_x5", bus.rs1_data, 32'hDEADBEEF);
    stepClock();
    readPorts(5'd5, 5'd0);
    checkOutput("commit_x5", bus.rs1_data, 32'hDEADBEEF);

    // Write to x0 occupies a slot but never shows up.
    applyStimulus(1'b1, 5'd0, 32'h1234, 1'b0, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd5, 5'd0);
    checkOutput("x0_queued_reads_0", bus.rs2_data, 32'h0);
    stepClock();
    readPorts(5'd5, 5'd0);
    checkOutput("x0_committed_reads_0", bus.rs2_data, 32'h0);

    // Fill under hold: two writes to x3, youngest visible.
    applyStimulus(1'b1, 5'd3, 32'h11, 1'b1, 1'b0, 5'd0);
    stepClock();
    readPorts(5'd3, 5'd0);
    checkOutput("fill_first_x3", bus.rs1_data, 32'h11);
    applyStimulus(1'b1, 5'd3, 32'h22, 1'b1, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0);
    readPorts(5'd3, 5'd3);
    checkOutput("full_not_ready", 32'(bus.wb_ready), 32'd0);
    checkOutput("youngest_wins_x3", bus.rs1_data, 32'h22);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    stepClock();
    readPorts(5'd3, 5'd3);
    checkOutput("drain1_ready", 32'(bus.wb_ready), 32'd1);
    checkOutput("drain1_x3", bus.rs2_data, 32'h22);
    stepClock();
    readPorts(5'd3, 5'd3);
    checkOutput("drain2_x3", bus.rs1_data, 32'h22);

    // Scoreboard: issue marks busy; commit clears it.
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    stepClock();
    applyStimulus(1'b1, 5'd7, 32'h77, 1'b0, 1'b0, 5'd0);
    readPorts(5'd7, 5'd8);
    checkOutput("busy_x7_set", 32'(bus.rs1_busy), 32'd1);
    checkOutput("busy_x8_clear", 32'(bus.rs2_busy), 32'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd7, 5'd8);
    checkOutput("busy_x7_queued", 32'(bus.rs1_busy), 32'd1);
    stepClock();
    readPorts(5'd7, 5'd8);
    checkOutput("busy_x7_committed", 32'(bus.rs1_busy), 32'd0);
    checkOutput("data_x7_committed", bus.rs1_data, 32'h77);

    // Issue and commit of x7 on the same edge: busy stays set.
    applyStimulus(1'b1, 5'd7, 32'h78, 1'b0, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd7);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b1, 5'd0);
    readPorts(5'd7, 5'd0);
    checkOutput("busy_set_wins", 32'(bus.rs1_busy), 32'd1);
    checkOutput("data_x7_second", bus.rs1_data, 32'h78);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd7, 5'd0);
    checkOutput("busy_x0_never", 32'(bus.rs2_busy), 32'd0);

    // Push and pop together at count 1, then blocked push when full.
    applyStimulus(1'b1, 5'd9, 32'hA1, 1'b1, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b1, 5'd10, 32'hB2, 1'b0, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0);
    readPorts(5'd9, 5'd10);
    checkOutput("pushpop_x9_committed", bus.rs1_data, 32'hA1);
    checkOutput("pushpop_x10_queued", bus.rs2_data, 32'hB2);
    checkOutput("pushpop_ready", 32'(bus.wb_ready), 32'd1);
    applyStimulus(1'b1, 5'd10, 32'hB3, 1'b1, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b1, 5'd11, 32'hC4, 1'b0, 1'b0, 5'd0);
    readPorts(5'd11, 5'd10);
    checkOutput("full_again_not_ready", 32'(bus.wb_ready), 32'd0);
    checkOutput("full_x10_youngest", bus.rs2_data, 32'hB3);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    readPorts(5'd11, 5'd10);
    checkOutput("full_push_rejected", bus.rs1_data, 32'h0);
    checkOutput("order_x10_pending", bus.rs2_data, 32'hB3);
    stepClock();
    stepClock();
    readPorts(5'd11, 5'd10);
    checkOutput("rejected_never_commits", bus.rs1_data, 32'h0);
    checkOutput("order_x10_final", bus.rs2_data, 32'hB3);

    // Reset with two held entries and a busy register pending.
    applyStimulus(1'b1, 5'd12, 32'h55, 1'b1, 1'b1, 5'd14);
    stepClock();
    applyStimulus(1'b1, 5'd13, 32'h66, 1'b1, 1'b0, 5'd0);
    stepClock();
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b1, 1'b0, 5'd0);
    readPorts(5'd12, 5'd14);
    checkOutput("pre_reset_x12_queued", bus.rs1_data, 32'h55);
    checkOutput("pre_reset_busy_x14", 32'(bus.rs2_busy), 32'd1);
    rst = 1'b1;
    stepClock();
    readPorts(5'd12, 5'd13);
    checkOutput("midop_ready_in_reset", 32'(bus.wb_ready), 32'd0);
    applyStimulus(1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 5'd0);
    stepClock();
    rst = 1'b0;
    stepClock();
    stepClock();
    readPorts(5'd12, 5'd13);
    checkOutput("post_reset_x12", bus.rs1_data, 32'h0);
    checkOutput("post_reset_x13", bus.rs2_data, 32'h0);
    checkOutput("post_reset_ready", 32'(bus.wb_ready), 32'd1);
    readPorts(5'd14, 5'd7);
    checkOutput("post_reset_busy_x14", 32'(bus.rs1_busy), 32'd0);
    checkOutput("post_reset_busy_x7", 32'(bus.rs2_busy), 32'd0);
    readPorts(5'd5, 5'd9);
    checkOutput("post_reset_x5", bus.rs1_data, 32'h0);
    checkOutput("post_reset_x9", bus.rs2_data, 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
